// File: rtl/snake_pkg.sv
// rtl/snake_pkg.sv - shared cell codes, grid geometry and FSM states for the snake frame renderer
package snake_pkg;

  typedef enum logic [1:0] {
    CELL_EMPTY = 2'd0,
    CELL_BODY  = 2'd1,
    CELL_HEAD  = 2'd2,
    CELL_FOOD  = 2'd3
  } cell_t;

  typedef enum logic [1:0] {
    S_CLEAR = 2'd0,
    S_IDLE  = 2'd1,
    S_PEND  = 2'd2,
    S_COPY  = 2'd3
  } state_t;

  localparam int GRID_W  = 24;
  localparam int GRID_H  = 16;
  localparam int CELL_PX = 4;
  localparam int OLED_W  = 96;
  localparam int OLED_H  = 64;
  localparam int N_CELLS = 384;

  function automatic logic [8:0] cell_addr(input logic [3:0] y, input logic [4:0] x);
    return ({5'd0, y} * 9'(GRID_W)) + {4'd0, x};
  endfunction

endpackage

// File: rtl/snake_cell_ram.sv
// rtl/snake_cell_ram.sv - one 384x2 cell bank, synchronous write and two asynchronous reads
module snake_cell_ram
  import snake_pkg::*;
(
  input  logic       clk_i,
  input  logic       we_i,
  input  logic [8:0] waddr_i,
  input  logic [1:0] wdata_i,
  input  logic [8:0] raddr_a_i,
  input  logic [8:0] raddr_b_i,
  output logic [1:0] rdata_a_o,
  output logic [1:0] rdata_b_o
);

  logic [1:0] mem_q [0:N_CELLS-1];

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_a_o = mem_q[raddr_a_i];
  assign rdata_b_o = mem_q[raddr_b_i];

endmodule

// File: rtl/snake_frame_renderer.sv
// rtl/snake_frame_renderer.sv - double-buffered 24x16 cell grid rendered to RGB565 for the OLED driver
module snake_frame_renderer
  import snake_pkg::*;
#(
  parameter logic [15:0] COL_BG   = 16'h0000,
  parameter logic [15:0] COL_BODY = 16'h07E0,
  parameter logic [15:0] COL_HEAD = 16'hFFE0,
  parameter logic [15:0] COL_FOOD = 16'hF800,
  parameter bit          GAP_EN   = 1'b1
) (
  input  logic        clk6p25m,
  input  logic        reset,
  input  logic [12:0] pixel_index,
  input  logic        frame_begin,
  output logic [15:0] oled_data,
  input  logic        wr_valid,
  output logic        wr_ready,
  input  logic [4:0]  wr_x,
  input  logic [3:0]  wr_y,
  input  logic [1:0]  wr_type,
  input  logic        commit_req,
  output logic        commit_ack,
  output logic        busy
);

  state_t      state_q;
  logic [8:0]  cnt_q;
  logic        front_sel_q, wr_ready_q, busy_q, commit_ack_q;
  logic [8:0]  s1_addr_q;
  logic [1:0]  s1_lx_q, s1_ly_q;
  logic        s1_oor_q;
  logic [15:0] oled_q, pix_d;

  logic [6:0]  px;
  logic [5:0]  py;
  logic        we0, we1, wr_in_range;
  logic [8:0]  waddr;
  logic [1:0]  wdata;
  logic [1:0]  rd_a0, rd_a1, rd_b0, rd_b1, front_a, front_b;

  assign front_a     = front_sel_q ? rd_a1 : rd_a0;
  assign front_b     = front_sel_q ? rd_b1 : rd_b0;
  assign wr_in_range = (wr_x < 5'(GRID_W)) && ({1'b0, wr_y} < 5'(GRID_H));

  // Both banks share address/data; the enables pick which bank(s) take it.
  always_comb begin
    we0   = 1'b0;
    we1   = 1'b0;
    waddr = cnt_q;
    wdata = CELL_EMPTY;
    case (state_q)
      S_CLEAR: begin
        we0 = 1'b1;
        we1 = 1'b1;
      end
      S_IDLE: if (wr_valid && wr_ready_q && wr_in_range) begin
        waddr = cell_addr(wr_y, wr_x);
        wdata = wr_type;
        we0   = front_sel_q;
        we1   = ~front_sel_q;
      end
      S_COPY: begin
        wdata = front_b;
        we0   = front_sel_q;
        we1   = ~front_sel_q;
      end
      default: ;
    endcase
  end

  snake_cell_ram u_bank0 (
    .clk_i(clk6p25m), .we_i(we0), .waddr_i(waddr), .wdata_i(wdata),
    .raddr_a_i(s1_addr_q), .raddr_b_i(cnt_q), .rdata_a_o(rd_a0), .rdata_b_o(rd_b0)
  );

  snake_cell_ram u_bank1 (
    .clk_i(clk6p25m), .we_i(we1), .waddr_i(waddr), .wdata_i(wdata),
    .raddr_a_i(s1_addr_q), .raddr_b_i(cnt_q), .rdata_a_o(rd_a1), .rdata_b_o(rd_b1)
  );

  always_ff @(posedge clk6p25m or posedge reset) begin
    if (reset) begin
      state_q      <= S_CLEAR;
      cnt_q        <= '0;
      front_sel_q  <= 1'b0;
      wr_ready_q   <= 1'b0;
      busy_q       <= 1'b1;
      commit_ack_q <= 1'b0;
    end else begin
      commit_ack_q <= 1'b0;
      case (state_q)
        S_CLEAR, S_COPY: begin
          cnt_q <= cnt_q + 9'd1;
          if (cnt_q == 9'(N_CELLS - 1)) begin
            cnt_q      <= '0;
            state_q    <= S_IDLE;
            wr_ready_q <= 1'b1;
            busy_q     <= 1'b0;
          end
        end
        S_IDLE: if (commit_req) begin
          state_q    <= S_PEND;
          wr_ready_q <= 1'b0;
          busy_q     <= 1'b1;
        end
        S_PEND: if (frame_begin) begin
          front_sel_q  <= ~front_sel_q;
          commit_ack_q <= 1'b1;
          cnt_q        <= '0;
          state_q      <= S_COPY;
        end
        default: state_q <= S_CLEAR;
      endcase
    end
  end

  always_comb begin
    px = 7'(pixel_index % 13'(OLED_W));
    py = 6'(pixel_index / 13'(OLED_W));
  end

  // Bank contents are undefined until CLEAR finishes, so the palette is bypassed then.
  always_comb begin
    pix_d = COL_BG;
    if (state_q != S_CLEAR && !s1_oor_q) begin
      case (front_a)
        CELL_BODY: pix_d = (GAP_EN && (s1_lx_q == 2'(CELL_PX - 1) || s1_ly_q == 2'(CELL_PX - 1)))
                           ? COL_BG : COL_BODY;
        CELL_HEAD: pix_d = COL_HEAD;
        CELL_FOOD: pix_d = COL_FOOD;
        default:   pix_d = COL_BG;
      endcase
    end
  end

  always_ff @(posedge clk6p25m or posedge reset) begin
    if (reset) begin
      s1_addr_q <= '0;
      s1_lx_q   <= '0;
      s1_ly_q   <= '0;
      s1_oor_q  <= 1'b0;
      oled_q    <= '0;
    end else begin
      s1_addr_q <= cell_addr(py[5:2], px[6:2]);
      s1_lx_q   <= px[1:0];
      s1_ly_q   <= py[1:0];
      s1_oor_q  <= pixel_index >= 13'(OLED_W * OLED_H);
      oled_q    <= pix_d;
    end
  end

  assign oled_data  = oled_q;
  assign wr_ready   = wr_ready_q;
  assign busy       = busy_q;
  assign commit_ack = commit_ack_q;

endmodule

// File: tb/tb_snake_frame_renderer.sv
// tb/tb_snake_frame_renderer.sv - scoreboard bench with a grid-level reference model
module tb_snake_frame_renderer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [12:0] pixel_index = '0;
  logic        frame_begin = 1'b0;
  logic [15:0] oled_data;
  logic        wr_valid = 1'b0;
  logic        wr_ready;
  logic [4:0]  wr_x = '0;
  logic [3:0]  wr_y = '0;
  logic [1:0]  wr_type = '0;
  logic        commit_req = 1'b0;
  logic        commit_ack;
  logic        busy;

  always #5 clk = ~clk;

  snake_frame_renderer dut (
    .clk6p25m(clk), .reset(reset), .pixel_index(pixel_index), .frame_begin(frame_begin),
    .oled_data(oled_data), .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_x(wr_x),
    .wr_y(wr_y), .wr_type(wr_type), .commit_req(commit_req), .commit_ack(commit_ack),
    .busy(busy)
  );

  int total = 0;
  int bad = 0;
  logic [1:0]  m_front [384];
  logic [1:0]  m_back  [384];
  logic [15:0] exp_q [$];
  int          idx_q [$];
  logic        issue = 1'b0;
  logic        v1 = 1'b0;
  logic        v2 = 1'b0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  function automatic logic [15:0] model_pix(input int idx);
    int x, y;
    logic [1:0] t;
    if (idx >= 96 * 64) return 16'h0000;
    x = idx % 96;
    y = idx / 96;
    t = m_front[(y / 4) * 24 + x / 4];
    case (t)
      2'd1:    return (x % 4 == 3 || y % 4 == 3) ? 16'h0000 : 16'h07E0;
      2'd2:    return 16'hFFE0;
      2'd3:    return 16'hF800;
      default: return 16'h0000;
    endcase
  endfunction

  always @(posedge clk) begin
    v1 <= issue;
    v2 <= v1;
  end

  always @(negedge clk) begin
    if (v2) begin
      if (exp_q.size() == 0) begin
        chk("pix_underflow", 32'(exp_q.size()), 1);
      end else begin
        int         i;
        logic [15:0] e;
        e = exp_q.pop_front();
        i = idx_q.pop_front();
        chk($sformatf("pix[%0d]", i), 32'(oled_data), 32'(e));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pix(input int idx, input logic [15:0] e);
    pixel_index = 13'(idx);
    issue = 1'b1;
    exp_q.push_back(e);
    idx_q.push_back(idx);
    tick();
    issue = 1'b0;
  endtask

  task automatic pixm(input int idx);
    pix(idx, model_pix(idx));
  endtask

  task automatic drain();
    repeat (3) tick();
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (!wr_ready && n < 2000) begin
      tick();
      n++;
    end
    if (!wr_ready) chk("wr_ready_timeout", 32'(wr_ready), 1);
  endtask

  task automatic reset_dut();
    reset = 1'b1;
    repeat (3) tick();
    chk("rst_oled", 32'(oled_data), 0);
    chk("rst_wr_ready", 32'(wr_ready), 0);
    chk("rst_busy", 32'(busy), 1);
    chk("rst_ack", 32'(commit_ack), 0);
    foreach (m_front[i]) begin
      m_front[i] = 2'd0;
      m_back[i]  = 2'd0;
    end
    reset = 1'b0;
    for (int i = 0; i < 383; i++) pixm($urandom_range(0, 8191));
    chk("clear_wr_ready", 32'(wr_ready), 0);
    chk("clear_busy", 32'(busy), 1);
    tick();
    chk("clear_done_wr_ready", 32'(wr_ready), 1);
    chk("clear_done_busy", 32'(busy), 0);
    drain();
  endtask

  task automatic write_cell(input int x, input int y, input logic [1:0] t);
    int n;
    wait_ready(n);
    wr_x = 5'(x);
    wr_y = 4'(y);
    wr_type = t;
    wr_valid = 1'b1;
    tick();
    wr_valid = 1'b0;
    if (x < 24 && y < 16) m_back[y * 24 + x] = t;
  endtask

  task automatic commit(input bit with_wr, input int x, input int y, input logic [1:0] t,
                        input bit fb_same);
    int n;
    wait_ready(n);
    if (with_wr) begin
      wr_x = 5'(x);
      wr_y = 4'(y);
      wr_type = t;
      wr_valid = 1'b1;
    end
    commit_req = 1'b1;
    frame_begin = fb_same;
    tick();
    wr_valid = 1'b0;
    commit_req = 1'b0;
    frame_begin = 1'b0;
    if (with_wr && x < 24 && y < 16) m_back[y * 24 + x] = t;
    chk("pend_ack", 32'(commit_ack), 0);
    chk("pend_wr_ready", 32'(wr_ready), 0);
    chk("pend_busy", 32'(busy), 1);
    repeat ($urandom_range(0, 5)) tick();
    frame_begin = 1'b1;
    tick();
    frame_begin = 1'b0;
    chk("swap_ack", 32'(commit_ack), 1);
    m_front = m_back;
    tick();
    chk("ack_pulse_end", 32'(commit_ack), 0);
    wait_ready(n);
    chk("copy_len", 32'(n), 383);
  endtask

  task automatic full_scan();
    for (int i = 0; i < 96 * 64; i++) pixm(i);
    drain();
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    int n;
    reset_dut();

    write_cell(3, 2, 2'd2);
    write_cell(0, 0, 2'd1);
    commit(1'b0, 0, 0, 2'd0, 1'b0);
    pix(780, 16'hFFE0);
    pix(779, 16'h0000);
    pix(0, 16'h07E0);
    pix(1, 16'h07E0);
    pix(2, 16'h07E0);
    pix(96, 16'h07E0);
    pix(3, 16'h0000);
    pix(288, 16'h0000);
    pix(291, 16'h0000);
    drain();

    write_cell(24, 5, 2'd2);
    chk("oob_wr_ready", 32'(wr_ready), 1);
    write_cell(31, 15, 2'd3);
    chk("oob_wr_ready2", 32'(wr_ready), 1);
    commit(1'b1, 23, 15, 2'd3, 1'b1);
    pix(6200, 16'h0000);
    pix(8191, 16'h0000);
    full_scan();

    write_cell(10, 10, 2'd2);
    commit_req = 1'b1;
    tick();
    for (int i = 0; i < 1000; i++) begin
      pixm($urandom_range(0, 8191));
      chk("hold_wr_ready", 32'(wr_ready), 0);
      chk("hold_ack", 32'(commit_ack), 0);
    end
    commit_req = 1'b0;
    drain();
    frame_begin = 1'b1;
    tick();
    frame_begin = 1'b0;
    chk("hold_swap_ack", 32'(commit_ack), 1);
    m_front = m_back;
    wait_ready(n);
    chk("hold_copy_len", 32'(n), 384);
    pix(10 * 4 * 96 + 41, 16'hFFE0);
    drain();

    for (int r = 0; r < 4; r++) begin
      for (int w = 0; w < 20; w++)
        write_cell($urandom_range(0, 31), $urandom_range(0, 15), 2'($urandom_range(0, 3)));
      commit($urandom_range(0, 1), $urandom_range(0, 25), $urandom_range(0, 15),
             2'($urandom_range(0, 3)), $urandom_range(0, 1));
      for (int p = 0; p < 300; p++) pixm($urandom_range(0, 8191));
      drain();
    end
    full_scan();

    write_cell(5, 5, 2'd3);
    commit_req = 1'b1;
    tick();
    commit_req = 1'b0;
    frame_begin = 1'b1;
    tick();
    frame_begin = 1'b0;
    chk("rc_swap_ack", 32'(commit_ack), 1);
    repeat (200) tick();
    reset_dut();
    full_scan();

    chk("queue_empty", 32'(exp_q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
